bin2bcd: RTL

Sequential binary-to-BCD converter. It is the inverse of the team's BCD-to-binary block and takes the same kind of start/ready/done_tick handshake. A W-bit unsigned binary value is converted to four packed BCD digits using shift-and-add-3 (double dabble), one bit per clock. It sits between arithmetic/counter logic and the seven-segment display path.

---
 rtl/bin2bcd_if.sv | 26 ++
 rtl/bin2bcd.sv | 109 ++++++++++
 2 files changed

// File: rtl/bin2bcd_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master side requests a conversion; the slave side (the converter) returns the digits.
`timescale 1ns/1ps
interface bin2bcd_if #(
    parameter int W = 14
);
    logic         start;
    logic [W-1:0] bin;
    logic         ready;
    logic         done_tick;
    logic [3:0]   bcd3;
    logic [3:0]   bcd2;
    logic [3:0]   bcd1;
    logic [3:0]   bcd0;
    logic         overflow;

    modport master (
        output start, bin,
        input  ready, done_tick, bcd3, bcd2, bcd1, bcd0, overflow
    );

    modport slave (
        input  start, bin,
        output ready, done_tick, bcd3, bcd2, bcd1, bcd0, overflow
    );
endinterface

// File: rtl/bin2bcd.sv
// Sequential W-bit binary to 4-digit packed BCD converter (double dabble, one bit per clock).
// Digits beyond 9999 wrap modulo 10000 and are flagged through overflow.
`timescale 1ns/1ps
module bin2bcd #(
    parameter int W = 14
) (
    input  logic      clk,
    input  logic      reset,
    bin2bcd_if.slave  bus
);
    localparam int CW = (W > 14) ? W : 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [4:0]      n_r;
    logic [W-1:0]    shreg_r;
    logic [15:0]     dig_r;
    logic            ov_next_r;
    logic [15:0]     bcd_r;
    logic            ov_r;

    logic [15:0]     adj_s;
    logic [16+W-1:0] shifted_s;
    logic [15:0]     dig_shift_s;
    logic [W-1:0]    sh_shift_s;
    logic [CW-1:0]   bin_ext_s;
    logic            ov_cap_s;

    function automatic logic [15:0] add3_digits(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = d[4*i +: 4];
            end
        end
        return r;
    endfunction

    // One double-dabble step; the top bit falling off the shift is the discarded digit-3 carry.
    always_comb begin
        adj_s       = add3_digits(dig_r);
        shifted_s   = {adj_s, shreg_r} << 1;
        dig_shift_s = shifted_s[16+W-1:W];
        sh_shift_s  = shifted_s[W-1:0];
        bin_ext_s   = CW'(bus.bin);
        ov_cap_s    = (bin_ext_s > CW'(9999));
    end

    // Control FSM with datapath and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            n_r       <= 5'd0;
            shreg_r   <= '0;
            dig_r     <= 16'd0;
            ov_next_r <= 1'b0;
            bcd_r     <= 16'd0;
            ov_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        shreg_r   <= bus.bin;
                        dig_r     <= 16'd0;
                        n_r       <= 5'(W);
                        ov_next_r <= ov_cap_s;
                        state_r   <= OP;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                OP: begin
                    dig_r   <= dig_shift_s;
                    shreg_r <= sh_shift_s;
                    n_r     <= n_r - 5'd1;
                    if (n_r == 5'd1) begin
                        bcd_r   <= dig_shift_s;
                        ov_r    <= ov_next_r;
                        state_r <= DONE;
                    end else begin
                        state_r <= OP;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = (state_r == IDLE);
    assign bus.done_tick = (state_r == DONE);
    assign bus.bcd3      = bcd_r[15:12];
    assign bus.bcd2      = bcd_r[11:8];
    assign bus.bcd1      = bcd_r[7:4];
    assign bus.bcd0      = bcd_r[3:0];
    assign bus.overflow  = ov_r;
endmodule
